// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
`timescale 1ns/1ps
package ps2_host_tx_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] REQ       = 3'd2;
    localparam logic [2:0] SHIFT     = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;
    localparam logic [2:0] ERROR     = 3'd6;

    localparam logic [3:0] PARITY_INDEX = 4'd8;
    localparam logic [3:0] STOP_INDEX   = 4'd9;
    localparam logic [3:0] ACK_INDEX    = 4'd10;

    function automatic logic odd_parity(input logic [7:0] value);
        return ~^value;
    endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a registered
// falling-edge strobe on the clock line (seen 3 cycles after the pin moves).
`timescale 1ns/1ps
module ps2_host_tx_sync (
    input  logic clock,
    input  logic reset,
    input  logic device_clock,
    input  logic device_data,
    output logic clock_synced,
    output logic data_synced,
    output logic clock_fall
);

    logic clock_meta;
    logic clock_prev;
    logic data_meta;

    // Idle PS/2 lines float high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clock_meta   <= 1'b1;
            clock_synced <= 1'b1;
            clock_prev   <= 1'b1;
            data_meta    <= 1'b1;
            data_synced  <= 1'b1;
            clock_fall   <= 1'b0;
        end else begin
            clock_meta   <= device_clock;
            clock_synced <= clock_meta;
            clock_prev   <= clock_synced;
            data_meta    <= device_data;
            data_synced  <= data_meta;
            clock_fall   <= clock_prev & ~clock_synced;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, bit shift on the
// device's falling clock edges, acknowledge check, with an idle-clock timeout.
`timescale 1ns/1ps
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter logic [15:0] inhibit_time = 16'd1500,
    parameter logic [15:0] over_time    = 16'd60000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       device_clock,
    input  logic       device_data,
    output logic       device_clock_drive_low,
    output logic       device_data_drive_low,
    input  logic [7:0] tx_data,
    input  logic       tx_request,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    logic [2:0]  state;
    logic [15:0] count;
    logic [3:0]  index;
    logic [7:0]  shift;
    logic        parity;
    logic        clock_synced;
    logic        data_synced;
    logic        clock_fall;
    logic        timed_out;
    logic        bit_drive;

    ps2_host_tx_sync sync (
        .clock        (clock),
        .reset        (reset),
        .device_clock (device_clock),
        .device_data  (device_data),
        .clock_synced (clock_synced),
        .data_synced  (data_synced),
        .clock_fall   (clock_fall)
    );

    assign timed_out = (count == over_time - 16'd1);

    // Level the data line should take for the bit at the current index.
    always_comb begin
        bit_drive = 1'b0;
        if (index < PARITY_INDEX) begin
            bit_drive = ~shift[index[2:0]];
        end else if (index == PARITY_INDEX) begin
            bit_drive = ~parity;
        end else if (index == STOP_INDEX) begin
            bit_drive = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            count                  <= '0;
            index                  <= '0;
            shift                  <= '0;
            parity                 <= 1'b0;
            busy                   <= 1'b0;
            tx_done                <= 1'b0;
            tx_error               <= 1'b0;
            device_clock_drive_low <= 1'b0;
            device_data_drive_low  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_request) begin
                        shift                  <= tx_data;
                        parity                 <= odd_parity(tx_data);
                        busy                   <= 1'b1;
                        device_clock_drive_low <= 1'b1;
                        count                  <= '0;
                        index                  <= '0;
                        state                  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    // The REQ cycle completes the hold, so the clock stays low inhibit_time cycles in total.
                    count <= count + 16'd1;
                    if (count == inhibit_time - 16'd2) begin
                        device_data_drive_low <= 1'b1;
                        state                 <= REQ;
                    end
                end
                REQ: begin
                    device_clock_drive_low <= 1'b0;
                    count                  <= '0;
                    index                  <= '0;
                    state                  <= SHIFT;
                end
                SHIFT: begin
                    if (clock_fall) begin
                        count <= '0;
                        if (index == ACK_INDEX) begin
                            if (data_synced) begin
                                tx_error              <= 1'b1;
                                busy                  <= 1'b0;
                                device_data_drive_low <= 1'b0;
                                state                 <= ERROR;
                            end else begin
                                state <= WAIT_IDLE;
                            end
                        end else begin
                            device_data_drive_low <= bit_drive;
                            index                 <= index + 4'd1;
                        end
                    end else if (timed_out) begin
                        tx_error              <= 1'b1;
                        busy                  <= 1'b0;
                        device_data_drive_low <= 1'b0;
                        state                 <= ERROR;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (clock_synced && data_synced) begin
                        tx_done               <= 1'b1;
                        busy                  <= 1'b0;
                        device_data_drive_low <= 1'b0;
                        state                 <= DONE;
                    end else if (clock_fall) begin
                        count <= '0;
                    end else if (timed_out) begin
                        tx_error              <= 1'b1;
                        busy                  <= 1'b0;
                        device_data_drive_low <= 1'b0;
                        state                 <= ERROR;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                DONE: begin
                    tx_done <= 1'b0;
                    state   <= IDLE;
                end
                ERROR: begin
                    tx_error               <= 1'b0;
                    device_clock_drive_low <= 1'b0;
                    device_data_drive_low  <= 1'b0;
                    state                  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int          HALF = 40;
    localparam logic [15:0] OVER = 16'd2000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       device_clock;
    logic       device_data;
    logic       device_clock_drive_low;
    logic       device_data_drive_low;
    logic [7:0] tx_data = 8'h00;
    logic       tx_request = 1'b0;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    assign device_clock = ~(device_clock_drive_low | dev_clk_low);
    assign device_data  = ~(device_data_drive_low | dev_data_low);

    ps2_host_tx #(.inhibit_time(16'd1500), .over_time(OVER)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .device_clock           (device_clock),
        .device_data            (device_data),
        .device_clock_drive_low (device_clock_drive_low),
        .device_data_drive_low  (device_data_drive_low),
        .tx_data                (tx_data),
        .tx_request             (tx_request),
        .busy                   (busy),
        .tx_done                (tx_done),
        .tx_error               (tx_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    int         cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         rts_cyc = 0;
    int         err_cyc = 0;
    logic       done_busy = 1'b1;
    logic [2:0] err_lines = 3'b111;
    logic       prev_ddl = 1'b0;

    always @(negedge clock) begin
        if (device_data_drive_low && !prev_ddl) rts_cyc = cyc;
        prev_ddl = device_data_drive_low;
        if (tx_done) begin
            done_cnt++;
            done_busy = busy;
        end
        if (tx_error) begin
            err_cnt++;
            err_cyc = cyc;
            err_lines = {device_clock_drive_low, device_data_drive_low, busy};
        end
        cyc++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_req(input logic [7:0] b);
        @(negedge clock);
        tx_data    = b;
        tx_request = 1'b1;
        @(negedge clock);
        tx_request = 1'b0;
    endtask

    task automatic check_inhibit(input string tag);
        int n;
        int d_at;
        n = 0;
        d_at = -1;
        while (device_clock_drive_low === 1'b1 && n < 5000) begin
            if (device_data_drive_low === 1'b1 && d_at < 0) d_at = n;
            n++;
            @(negedge clock);
        end
        chk({tag, "_inhibit_len"}, n, 1500);
        chk({tag, "_rts_lead"}, d_at, 1499);
    endtask

    // Device model: waits for request-to-send, then generates nclk clock pulses,
    // sampling the data line on each rising edge; ACKs after the stop bit unless nack.
    task automatic device_frame(input int nclk, input bit nack, output logic [10:0] smp, output bit ok);
        int n;
        smp = '0;
        n = 0;
        while (!(device_clock === 1'b1 && device_data === 1'b0) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        ok = (n < 5000);
        if (ok) begin
            repeat (20) @(negedge clock);
            for (int k = 1; k <= nclk; k++) begin
                dev_clk_low = 1'b1;
                repeat (HALF) @(negedge clock);
                dev_clk_low = 1'b0;
                #1;
                smp[k-1] = device_data;
                if (k == 10 && !nack) dev_data_low = 1'b1;
                if (k == 11) dev_data_low = 1'b0;
                repeat (HALF) @(negedge clock);
            end
        end
    endtask

    typedef struct {
        logic [7:0] b;
        bit         nack;
        logic       par;
        int         done;
        int         err;
    } vec_t;

    vec_t        tbl [6];
    logic [10:0] smp;
    bit          ok;
    int          d0;
    int          e0;
    int          n;

    initial begin
        tbl[0] = '{8'hED, 1'b0, 1'b1, 1, 0};
        tbl[1] = '{8'h00, 1'b0, 1'b1, 1, 0};
        tbl[2] = '{8'h01, 1'b0, 1'b0, 1, 0};
        tbl[3] = '{8'hFF, 1'b0, 1'b1, 1, 0};
        tbl[4] = '{8'hAA, 1'b1, 1'b1, 0, 1};
        tbl[5] = '{8'hF4, 1'b0, 1'b0, 1, 0};

        repeat (3) @(negedge clock);
        chk("reset_clk_dl", device_clock_drive_low, 0);
        chk("reset_data_dl", device_data_drive_low, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", tx_done, 0);
        chk("reset_error", tx_error, 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("idle_clk_dl", device_clock_drive_low, 0);

        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            start_req(tbl[i].b);
            chk($sformatf("v%0d_busy_on", i), busy, 1);
            check_inhibit($sformatf("v%0d", i));
            device_frame(11, tbl[i].nack, smp, ok);
            chk($sformatf("v%0d_rts_seen", i), ok, 1);
            repeat (30) @(negedge clock);
            chk($sformatf("v%0d_data", i), smp[7:0], tbl[i].b);
            chk($sformatf("v%0d_parity", i), smp[8], tbl[i].par);
            chk($sformatf("v%0d_stop", i), smp[9], 1);
            chk($sformatf("v%0d_done_pulses", i), done_cnt - d0, tbl[i].done);
            chk($sformatf("v%0d_err_pulses", i), err_cnt - e0, tbl[i].err);
            chk($sformatf("v%0d_busy_off", i), busy, 0);
            chk($sformatf("v%0d_lines_rel", i), {device_clock_drive_low, device_data_drive_low}, 0);
            if (tbl[i].done != 0) chk($sformatf("v%0d_busy_at_done", i), done_busy, 0);
            if (tbl[i].err != 0) chk($sformatf("v%0d_lines_at_err", i), err_lines, 0);
        end

        // Timeout: the device never clocks after release.
        d0 = done_cnt;
        e0 = err_cnt;
        start_req(8'h12);
        n = 0;
        while (err_cnt == e0 && n < 6000) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk("to_err_pulses", err_cnt - e0, 1);
        chk("to_latency", err_cyc - rts_cyc, OVER + 1);
        chk("to_lines_busy", err_lines, 0);
        chk("to_no_done", done_cnt - d0, 0);
        repeat (5) @(negedge clock);

        // Second request mid-frame is ignored.
        d0 = done_cnt;
        e0 = err_cnt;
        start_req(8'h3C);
        fork
            device_frame(11, 1'b0, smp, ok);
            begin
                repeat (1900) @(negedge clock);
                chk("busy_mid_frame", busy, 1);
                tx_data    = 8'h55;
                tx_request = 1'b1;
                @(negedge clock);
                tx_request = 1'b0;
            end
        join
        repeat (2500) @(negedge clock);
        chk("busyreq_rts_seen", ok, 1);
        chk("busyreq_data", smp[7:0], 8'h3C);
        chk("busyreq_parity", smp[8], 1);
        chk("busyreq_done_pulses", done_cnt - d0, 1);
        chk("busyreq_err_pulses", err_cnt - e0, 0);
        chk("busyreq_no_restart", {device_clock_drive_low, busy}, 0);

        // Reset after the 4th bit releases both lines without a clock edge.
        start_req(8'hA5);
        device_frame(4, 1'b0, smp, ok);
        chk("rst_pre_data_dl", device_data_drive_low, 1);
        chk("rst_pre_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_clk_dl", device_clock_drive_low, 0);
        chk("rst_data_dl", device_data_drive_low, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {tx_done, tx_error}, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        d0 = done_cnt;
        e0 = err_cnt;
        start_req(8'h5A);
        check_inhibit("post_rst");
        device_frame(11, 1'b0, smp, ok);
        repeat (30) @(negedge clock);
        chk("post_rst_data", smp[7:0], 8'h5A);
        chk("post_rst_parity", smp[8], 1);
        chk("post_rst_done_pulses", done_cnt - d0, 1);
        chk("post_rst_err_pulses", err_cnt - e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
